key_expand_sequencer: RTL and testbench

Sequential AES-128 key-expansion controller. It accepts a 128-bit cipher key and iteratively generates round keys 0..10, one round per clock, into an internal 11-entry round-key bank. It then streams those keys to the round datapath in forward (encrypt) or reverse (decrypt) order over a valid/ready handshake. It replaces the flat 1408-bit combinational expansion on the cipher path with a bounded 11-cycle, single-round-step structure.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/key_expand_sequencer_if.sv | 30 +++
 rtl/key_round_step.sv | 31 +++
 rtl/key_expand_sequencer.sv | 149 ++++++++++++++
 tb/tb_key_expand_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared state type, round constants and S-box
// for the AES-128 key-expansion sequencer.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0x00 sits in the top byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/key_expand_sequencer_if.sv
// key_expand_sequencer_if: key load, status and
// round-key stream handshake bundle.
interface key_expand_sequencer_if;

  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         start;
  logic         dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         rk_last;

  modport master (
    output key_load, key_in, start, dir, rk_ready,
    input  key_ready, busy, keys_valid,
    input  rk_valid, rk_out, rk_index, rk_last
  );

  modport slave (
    input  key_load, key_in, start, dir, rk_ready,
    output key_ready, busy, keys_valid,
    output rk_valid, rk_out, rk_index, rk_last
  );

endinterface

// File: rtl/key_round_step.sv
// key_round_step: one AES-128 key-schedule round,
// RotWord/SubWord/Rcon on w3 then the XOR chain.
module key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  assign w_t = {
    sbox(w_w3[23:16]) ^ i_rcon,
    sbox(w_w3[15:8]),
    sbox(w_w3[7:0]),
    sbox(w_w3[31:24])
  };

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/key_expand_sequencer.sv
// key_expand_sequencer: iterative AES-128 key expansion
// into an 11-entry bank, streamed fwd or rev.
module key_expand_sequencer
  import aes_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  key_expand_sequencer_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t       r_state, w_state_n;
  logic [3:0]   r_cnt, w_cnt_n;
  logic [3:0]   r_idx, w_idx_n;
  logic         r_dir, w_dir_n;
  logic [127:0] r_bank [0:NUM_ROUNDS];

  logic         w_we;
  logic [3:0]   w_waddr;
  logic [127:0] w_wdata;
  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev;
  logic [127:0] w_step;
  logic [7:0]   w_rcon;
  logic         w_last;
  logic         w_bad;

  assign w_prev_idx = r_cnt - 4'd1;
  assign w_prev = (w_prev_idx <= LAST) ?
                  r_bank[w_prev_idx] : '0;
  assign w_rcon = (r_cnt != 4'd0 && r_cnt <= LAST) ?
                  RCON[r_cnt] : 8'h00;

  key_round_step u_step (
    .i_key  (w_prev),
    .i_rcon (w_rcon),
    .o_key  (w_step)
  );

  assign w_last = r_dir ? (r_idx == 4'd0) : (r_idx == LAST);
  assign w_bad  = (r_cnt > LAST) || (r_idx > LAST);

  // State, counters and stream direction registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_dir   <= w_dir_n;
    end
  end

  // Next-state, counter update and bank write decode.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_dir_n   = r_dir;
    w_we      = 1'b0;
    w_waddr   = r_cnt;
    w_wdata   = w_step;
    if (clear || w_bad) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
      w_idx_n   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.key_load) begin
            w_we      = 1'b1;
            w_waddr   = '0;
            w_wdata   = bus.key_in;
            w_cnt_n   = 4'd1;
            w_state_n = EXPAND;
          end
        end
        EXPAND: begin
          w_we = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_n   = '0;
            w_state_n = READY;
          end else begin
            w_cnt_n = r_cnt + 4'd1;
          end
        end
        READY: begin
          if (bus.key_load) begin
            w_we      = 1'b1;
            w_waddr   = '0;
            w_wdata   = bus.key_in;
            w_cnt_n   = 4'd1;
            w_state_n = EXPAND;
          end else if (bus.start) begin
            w_dir_n   = bus.dir;
            w_idx_n   = bus.dir ? LAST : 4'd0;
            w_state_n = STREAM;
          end
        end
        STREAM: begin
          if (bus.rk_ready) begin
            if (w_last) begin
              w_idx_n   = '0;
              w_state_n = READY;
            end else if (r_dir) begin
              w_idx_n = r_idx - 4'd1;
            end else begin
              w_idx_n = r_idx + 4'd1;
            end
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
          w_idx_n   = '0;
        end
      endcase
    end
  end

  // Round-key bank, one entry written per cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_we) begin
      r_bank[w_waddr] <= w_wdata;
    end
  end

  assign bus.key_ready  = (r_state == IDLE) ||
                          (r_state == READY);
  assign bus.busy       = (r_state == EXPAND);
  assign bus.keys_valid = (r_state == READY) ||
                          (r_state == STREAM);
  assign bus.rk_valid   = (r_state == STREAM);
  assign bus.rk_last    = (r_state == STREAM) && w_last;
  assign bus.rk_index   = r_idx;
  assign bus.rk_out     = (r_idx <= LAST) ?
                          r_bank[r_idx] : '0;

endmodule

// File: tb/tb_key_expand_sequencer.sv
// tb_key_expand_sequencer: reference-key schedule,
// stream order, backpressure, collisions and aborts.
module tb_key_expand_sequencer;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;

  key_expand_sequencer_if u_if();

  key_expand_sequencer u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         last;
  } exp_t;

  typedef struct {
    logic dir;
    int   stall_idx;
    int   stall_len;
    logic ld_mid;
  } scen_t;

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] ref_rk [0:10];
  scen_t        scen [5];
  exp_t         sb [$];
  exp_t         m_e;

  task automatic chkk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chki(input string name,
                      input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b",
               name, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted transfer.
  always @(negedge clk) begin
    if (n_rst && u_if.rk_valid && u_if.rk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rk: got idx %0d expected none",
                 u_if.rk_index);
      end else begin
        m_e = sb.pop_front();
        chki("rk_index", int'(u_if.rk_index), int'(m_e.idx));
        chkk("rk_out", u_if.rk_out, m_e.rk);
        chk1("rk_last", u_if.rk_last, m_e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    u_if.key_in   = k;
    u_if.key_load = 1'b1;
    tick();
    u_if.key_load = 1'b0;
    n = 0;
    while (u_if.busy && n < 30) begin
      n++;
      tick();
    end
    chki("busy_cycles", n, 10);
    chk1("kv_after_load", u_if.keys_valid, 1'b1);
  endtask

  task automatic run_stream(input scen_t s);
    int n_xfer;
    int guard;
    int stalls;
    int first;
    stalls = s.stall_len;
    first  = s.dir ? 10 : 0;
    for (int k = 0; k < 11; k++) begin
      exp_t x;
      int   r;
      r      = s.dir ? 10 - k : k;
      x.idx  = 4'(r);
      x.rk   = ref_rk[r];
      x.last = (k == 10);
      sb.push_back(x);
    end
    u_if.dir      = s.dir;
    u_if.start    = 1'b1;
    u_if.rk_ready = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk1("start_lat", u_if.rk_valid, 1'b1);
    chki("first_idx", int'(u_if.rk_index), first);
    n_xfer = 0;
    guard  = 0;
    while (u_if.rk_valid && guard < 40) begin
      guard++;
      if (int'(u_if.rk_index) == s.stall_idx && stalls > 0) begin
        chkk("stall_out", u_if.rk_out, ref_rk[s.stall_idx]);
        chki("stall_idx", int'(u_if.rk_index), s.stall_idx);
        chk1("stall_last", u_if.rk_last, 1'b0);
        u_if.rk_ready = 1'b0;
        stalls--;
      end else begin
        u_if.rk_ready = 1'b1;
        n_xfer++;
      end
      if (s.ld_mid && u_if.rk_index == 4'd5) begin
        chk1("stream_kready", u_if.key_ready, 1'b0);
        u_if.key_in   = '1;
        u_if.key_load = 1'b1;
      end else begin
        u_if.key_load = 1'b0;
      end
      tick();
    end
    u_if.key_load = 1'b0;
    u_if.rk_ready = 1'b1;
    chki("stream_xfers", n_xfer, 11);
    chki("stream_cycles", guard, 11 + s.stall_len);
    chk1("post_kv", u_if.keys_valid, 1'b1);
    chk1("post_busy", u_if.busy, 1'b0);
    chki("sb_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    ref_rk[0]  = 128'h2B6BAAB2B3768EA3F69807D892BEB46D;
    ref_rk[1]  = 128'h84E696FD3790185EC1081F8653B6ABEB;
    ref_rk[2]  = 128'hC8847F10FF14674E3E1C78C86DAAD323;
    ref_rk[3]  = 128'h60E2592C9FF63E62A1EA46AACC409589;
    ref_rk[4]  = 128'h61C8FE67FE3EC0055FD486AF93941326;
    ref_rk[5]  = 128'h53B509BBAD8BC9BEF25F4F1161CB5C37;
    ref_rk[6]  = 128'h6CFF9354C1745AEA332B15FB52E049CC;
    ref_rk[7]  = 128'hCDC4D8540CB082BE3F9B97456D7BDE89;
    ref_rk[8]  = 128'h6CD97F686069FDD65FF26A933289B41A;
    ref_rk[9]  = 128'hD054DD4BB03D209DEFCF4A0EDD46FE14;
    ref_rk[10] = 128'hBCEF278A0CD20717E31D4D193E5BB30D;

    scen[0] = '{1'b0, -1, 0, 1'b0};
    scen[1] = '{1'b1, -1, 0, 1'b0};
    scen[2] = '{1'b0,  3, 5, 1'b0};
    scen[3] = '{1'b0, -1, 0, 1'b1};
    scen[4] = '{1'b1, -1, 0, 1'b0};

    u_if.key_load = 1'b0;
    u_if.key_in   = '0;
    u_if.start    = 1'b0;
    u_if.dir      = 1'b0;
    u_if.rk_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_kready", u_if.key_ready, 1'b1);
    chk1("rst_busy", u_if.busy, 1'b0);
    chk1("rst_kv", u_if.keys_valid, 1'b0);
    chk1("rst_rkv", u_if.rk_valid, 1'b0);
    chk1("rst_last", u_if.rk_last, 1'b0);
    chkk("rst_rkout", u_if.rk_out, '0);
    chki("rst_idx", int'(u_if.rk_index), 0);
    n_rst = 1'b1;
    tick();

    load_key(ref_rk[0]);
    for (int i = 0; i < 5; i++) begin
      run_stream(scen[i]);
    end

    u_if.key_in   = ref_rk[0];
    u_if.key_load = 1'b1;
    u_if.start    = 1'b1;
    tick();
    u_if.key_load = 1'b0;
    u_if.start    = 1'b0;
    chk1("col_busy", u_if.busy, 1'b1);
    chk1("col_kv", u_if.keys_valid, 1'b0);
    chk1("col_rkv", u_if.rk_valid, 1'b0);
    n = 0;
    while (u_if.busy && n < 30) begin
      n++;
      tick();
    end
    chki("col_busy_cycles", n, 10);
    chk1("col_kv_back", u_if.keys_valid, 1'b1);
    chk1("col_rkv_end", u_if.rk_valid, 1'b0);
    run_stream(scen[0]);

    u_if.key_in   = ref_rk[0];
    u_if.key_load = 1'b1;
    tick();
    u_if.key_load = 1'b0;
    repeat (4) tick();
    chk1("mid_busy", u_if.busy, 1'b1);
    n_rst = 1'b0;
    #1;
    chk1("arst_busy", u_if.busy, 1'b0);
    chk1("arst_kready", u_if.key_ready, 1'b1);
    chk1("arst_kv", u_if.keys_valid, 1'b0);
    chk1("arst_rkv", u_if.rk_valid, 1'b0);
    chkk("arst_rkout", u_if.rk_out, '0);
    chki("arst_idx", int'(u_if.rk_index), 0);
    tick();
    n_rst = 1'b1;
    tick();
    chk1("arst_idle", u_if.key_ready, 1'b1);

    load_key(ref_rk[0]);
    u_if.rk_ready = 1'b0;
    u_if.dir      = 1'b0;
    u_if.start    = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (2) tick();
    chk1("clr_pre_rkv", u_if.rk_valid, 1'b1);
    clear = 1'b1;
    #1;
    chk1("clr_sync", u_if.rk_valid, 1'b1);
    tick();
    clear = 1'b0;
    chk1("clr_rkv", u_if.rk_valid, 1'b0);
    chk1("clr_kready", u_if.key_ready, 1'b1);
    chk1("clr_kv", u_if.keys_valid, 1'b0);
    chk1("clr_busy", u_if.busy, 1'b0);
    u_if.rk_ready = 1'b1;
    load_key(ref_rk[0]);
    run_stream(scen[0]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
